// File: rtl/load_queue_pkg.sv
// Shared sizing, entry-state encodings and the entry record for the load queue.
package load_queue_pkg;
  localparam int LQ_NUM      = 8;
  localparam int LQ_SEL      = 3;
  localparam int CNT_W       = LQ_SEL + 1;
  localparam int ADDR_LEN    = 32;
  localparam int DATA_LEN    = 32;
  localparam int PHY_REG_SEL = 6;
  localparam int ROB_SEL     = 6;

  typedef enum logic [2:0] {
    LQ_FREE      = 3'd0,
    LQ_WAIT_ADDR = 3'd1,
    LQ_ADDR_RDY  = 3'd2,
    LQ_ISSUED    = 3'd3,
    LQ_DONE      = 3'd4
  } lq_state_e;

  typedef struct packed {
    lq_state_e              state;
    logic [PHY_REG_SEL-1:0] preg;
    logic [ROB_SEL-1:0]     rob;
    logic [ADDR_LEN-1:0]    addr;
  } lq_entry_t;
endpackage

// File: rtl/lq_oldest_select.sv
// Rotating-priority picker: first set bit of the ready mask scanning upward from head.
module lq_oldest_select
  import load_queue_pkg::*;
(
  input  logic [LQ_SEL-1:0] head,
  input  logic [LQ_NUM-1:0] ready,
  output logic              found,
  output logic [LQ_SEL-1:0] idx
);
  logic [LQ_SEL-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 0; i < LQ_NUM; i++) begin
      j = head + LQ_SEL'(i);
      if (!found && ready[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/load_queue.sv
// In-order allocate/retire load queue with oldest-first issue over a valid/ready port.
module load_queue
  import load_queue_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dispatch_lq_valid_1,
  input  logic                   dispatch_lq_valid_2,
  input  logic [PHY_REG_SEL-1:0] dst_preg_1,
  input  logic [PHY_REG_SEL-1:0] dst_preg_2,
  input  logic [ROB_SEL-1:0]     rob_idx_1,
  input  logic [ROB_SEL-1:0]     rob_idx_2,
  output logic [LQ_SEL-1:0]      alloc_idx_1,
  output logic [LQ_SEL-1:0]      alloc_idx_2,
  output logic                   lq_full,
  output logic                   lq_empty,
  input  logic                   addr_valid,
  input  logic [LQ_SEL-1:0]      addr_lq_idx,
  input  logic [ADDR_LEN-1:0]    addr_value,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_LEN-1:0]    mem_req_addr,
  output logic [LQ_SEL-1:0]      mem_req_tag,
  input  logic                   mem_resp_valid,
  input  logic [LQ_SEL-1:0]      mem_resp_tag,
  input  logic [DATA_LEN-1:0]    mem_resp_data,
  output logic                   wb_valid,
  output logic [PHY_REG_SEL-1:0] wb_preg,
  output logic [ROB_SEL-1:0]     wb_rob_idx,
  output logic [DATA_LEN-1:0]    wb_data,
  input  logic                   commit_valid,
  input  logic                   flush
);
  lq_entry_t              ent [LQ_NUM];
  logic [LQ_SEL-1:0]      head, tail, tail_p1;
  logic [CNT_W-1:0]       count;
  logic                   disp_a, disp_b, addr_hit, resp_hit, commit_hit, req_load;
  logic [1:0]             n_disp;
  logic [PHY_REG_SEL-1:0] preg_a;
  logic [ROB_SEL-1:0]     rob_a;
  logic [LQ_NUM-1:0]      rdy_mask;
  logic                   sel_found;
  logic [LQ_SEL-1:0]      sel_idx;
  logic [ADDR_LEN-1:0]    sel_addr;

  assign lq_full     = count > CNT_W'(LQ_NUM - 2);
  assign lq_empty    = count == '0;
  assign tail_p1     = tail + 1'b1;
  assign alloc_idx_1 = tail;
  assign alloc_idx_2 = tail_p1;

  // A lone slot-2 dispatch still lands at tail, so slot A is "whichever is valid first".
  assign disp_a = !lq_full && (dispatch_lq_valid_1 || dispatch_lq_valid_2);
  assign disp_b = !lq_full && dispatch_lq_valid_1 && dispatch_lq_valid_2;
  assign n_disp = {1'b0, disp_a} + {1'b0, disp_b};
  assign preg_a = dispatch_lq_valid_1 ? dst_preg_1 : dst_preg_2;
  assign rob_a  = dispatch_lq_valid_1 ? rob_idx_1  : rob_idx_2;

  assign addr_hit   = addr_valid && ent[addr_lq_idx].state == LQ_WAIT_ADDR;
  assign resp_hit   = mem_resp_valid && ent[mem_resp_tag].state == LQ_ISSUED;
  assign commit_hit = commit_valid && ent[head].state == LQ_DONE;
  assign req_load   = !mem_req_valid || mem_req_ready;

  // The arriving AGU address counts as ready this cycle so it can issue on the next.
  always_comb begin
    rdy_mask = '0;
    for (int i = 0; i < LQ_NUM; i++)
      rdy_mask[i] = (ent[i].state == LQ_ADDR_RDY) || (addr_hit && addr_lq_idx == LQ_SEL'(i));
  end

  lq_oldest_select u_sel (
    .head  (head),
    .ready (rdy_mask),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign sel_addr = (addr_hit && sel_idx == addr_lq_idx) ? addr_value : ent[sel_idx].addr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < LQ_NUM; i++) ent[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_tag   <= '0;
      wb_valid      <= 1'b0;
      wb_preg       <= '0;
      wb_rob_idx    <= '0;
      wb_data       <= '0;
    end else begin
      if (disp_a) begin
        ent[tail].state <= LQ_WAIT_ADDR;
        ent[tail].preg  <= preg_a;
        ent[tail].rob   <= rob_a;
        ent[tail].addr  <= '0;
      end
      if (disp_b) begin
        ent[tail_p1].state <= LQ_WAIT_ADDR;
        ent[tail_p1].preg  <= dst_preg_2;
        ent[tail_p1].rob   <= rob_idx_2;
        ent[tail_p1].addr  <= '0;
      end
      if (addr_hit) begin
        ent[addr_lq_idx].addr  <= addr_value;
        ent[addr_lq_idx].state <= LQ_ADDR_RDY;
      end
      if (req_load) begin
        mem_req_valid <= sel_found;
        if (sel_found) begin
          mem_req_addr        <= sel_addr;
          mem_req_tag         <= sel_idx;
          ent[sel_idx].state  <= LQ_ISSUED;
        end
      end
      wb_valid <= resp_hit;
      if (resp_hit) begin
        wb_preg                  <= ent[mem_resp_tag].preg;
        wb_rob_idx               <= ent[mem_resp_tag].rob;
        wb_data                  <= mem_resp_data;
        ent[mem_resp_tag].state  <= LQ_DONE;
      end
      if (commit_hit) begin
        ent[head].state <= LQ_FREE;
        head            <= head + 1'b1;
      end
      tail  <= tail + LQ_SEL'(n_disp);
      count <= count + CNT_W'(n_disp) - CNT_W'(commit_hit);
    end
  end
endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: dispatch, full boundary, issue ordering, writeback, flush, wrap.
module tb_load_queue;
  import load_queue_pkg::*;

  logic                   clk = 0;
  logic                   reset;
  logic                   dv1, dv2;
  logic [PHY_REG_SEL-1:0] p1, p2;
  logic [ROB_SEL-1:0]     r1, r2;
  logic [LQ_SEL-1:0]      a1, a2;
  logic                   full, empty;
  logic                   av;
  logic [LQ_SEL-1:0]      aidx;
  logic [ADDR_LEN-1:0]    aval;
  logic                   rq_v, rq_rdy;
  logic [ADDR_LEN-1:0]    rq_addr;
  logic [LQ_SEL-1:0]      rq_tag;
  logic                   rs_v;
  logic [LQ_SEL-1:0]      rs_tag;
  logic [DATA_LEN-1:0]    rs_data;
  logic                   wbv;
  logic [PHY_REG_SEL-1:0] wbp;
  logic [ROB_SEL-1:0]     wbr;
  logic [DATA_LEN-1:0]    wbd;
  logic                   cv, fl;

  int n_cmp = 0;
  int n_err = 0;

  load_queue dut (
    .clk(clk), .reset(reset),
    .dispatch_lq_valid_1(dv1), .dispatch_lq_valid_2(dv2),
    .dst_preg_1(p1), .dst_preg_2(p2), .rob_idx_1(r1), .rob_idx_2(r2),
    .alloc_idx_1(a1), .alloc_idx_2(a2), .lq_full(full), .lq_empty(empty),
    .addr_valid(av), .addr_lq_idx(aidx), .addr_value(aval),
    .mem_req_valid(rq_v), .mem_req_ready(rq_rdy), .mem_req_addr(rq_addr), .mem_req_tag(rq_tag),
    .mem_resp_valid(rs_v), .mem_resp_tag(rs_tag), .mem_resp_data(rs_data),
    .wb_valid(wbv), .wb_preg(wbp), .wb_rob_idx(wbr), .wb_data(wbd),
    .commit_valid(cv), .flush(fl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic v1, input logic v2, input int pa, input int pb);
    dv1 = v1; dv2 = v2;
    p1 = PHY_REG_SEL'(pa); r1 = ROB_SEL'(pa + 1);
    p2 = PHY_REG_SEL'(pb); r2 = ROB_SEL'(pb + 1);
    step();
    dv1 = 0; dv2 = 0;
  endtask

  task automatic addr(input int idx, input logic [31:0] v);
    av = 1; aidx = LQ_SEL'(idx); aval = v;
    step();
    av = 0;
  endtask

  initial begin
    reset = 1; dv1 = 0; dv2 = 0; p1 = 0; p2 = 0; r1 = 0; r2 = 0;
    av = 0; aidx = 0; aval = 0; rq_rdy = 0; rs_v = 0; rs_tag = 0; rs_data = 0;
    cv = 0; fl = 0;
    step(); step();
    reset = 0;

    // Reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_reqv", rq_v, 0);
    chk("rst_reqaddr", rq_addr, 0);
    chk("rst_wbv", wbv, 0);
    chk("rst_alloc1", a1, 0);
    chk("rst_alloc2", a2, 1);

    // Dual dispatch: entry 0 preg 5 rob 6, entry 1 preg 6 rob 7
    disp(1, 1, 5, 6);
    chk("dd_alloc1", a1, 2);
    chk("dd_alloc2", a2, 3);
    chk("dd_empty", empty, 0);
    chk("dd_full", full, 0);

    // Out-of-order addresses with a stalled memory port
    addr(1, 32'h100);
    chk("ooo_reqv0", rq_v, 1);
    chk("ooo_addr0", rq_addr, 32'h100);
    chk("ooo_tag0", rq_tag, 1);
    addr(0, 32'h200);
    for (int i = 0; i < 2; i++) begin
      chk("ooo_hold_addr", rq_addr, 32'h100);
      chk("ooo_hold_tag", rq_tag, 1);
      chk("ooo_hold_v", rq_v, 1);
      step();
    end
    chk("ooo_hold_addr", rq_addr, 32'h100);
    rq_rdy = 1;
    step();
    chk("ooo_next_v", rq_v, 1);
    chk("ooo_next_addr", rq_addr, 32'h200);
    chk("ooo_next_tag", rq_tag, 0);
    step();
    chk("ooo_drain_v", rq_v, 0);
    rq_rdy = 0;

    // Commit with head (entry 0) only ISSUED is ignored
    cv = 1; step(); cv = 0;

    // Response tag 1 -> writeback preg 6 rob 7
    rs_v = 1; rs_tag = 1; rs_data = 32'hDEADBEEF;
    step();
    rs_v = 0;
    chk("wb1_v", wbv, 1);
    chk("wb1_preg", wbp, 6);
    chk("wb1_rob", wbr, 7);
    chk("wb1_data", wbd, 32'hDEADBEEF);
    cv = 1; step(); cv = 0;    // head still not DONE
    chk("wb1_pulse", wbv, 0);
    rs_v = 1; rs_tag = 0; rs_data = 32'h12345678;
    step();
    chk("wb0_v", wbv, 1);
    chk("wb0_preg", wbp, 5);
    chk("wb0_data", wbd, 32'h12345678);
    rs_tag = 3; rs_data = 32'hBAD;   // entry 3 is FREE: dropped
    step();
    rs_v = 0;
    chk("drop_free_wbv", wbv, 0);

    // Full boundary: count 2 -> 7
    disp(1, 1, 20, 21);
    disp(1, 1, 22, 23);
    chk("fill6_full", full, 0);
    disp(0, 1, 0, 24);
    chk("fill7_full", full, 1);
    chk("fill7_alloc1", a1, 7);
    chk("fill7_alloc2", a2, 0);
    disp(1, 1, 30, 31);
    chk("full_ign_alloc", a1, 7);
    chk("full_ign_full", full, 1);
    cv = 1; step();
    chk("commit_full", full, 0);
    chk("commit_alloc", a1, 7);
    step(); cv = 0;     // retires entry 1 too; head = 2, count = 5

    // Flush with a pending request and two ISSUED entries
    addr(2, 32'h300);
    chk("fl_req2", rq_addr, 32'h300);
    addr(3, 32'h304);
    addr(4, 32'h308);
    rq_rdy = 1;
    step();
    chk("fl_req3", rq_tag, 3);
    step();
    chk("fl_req4", rq_tag, 4);
    chk("fl_req4_addr", rq_addr, 32'h308);
    fl = 1; step(); fl = 0;
    rq_rdy = 0;
    chk("fl_reqv", rq_v, 0);
    chk("fl_reqaddr", rq_addr, 0);
    chk("fl_empty", empty, 1);
    chk("fl_full", full, 0);
    chk("fl_alloc1", a1, 0);
    chk("fl_alloc2", a2, 1);
    rs_v = 1; rs_tag = 2; rs_data = 32'h55;
    step();
    rs_v = 0;
    chk("fl_late_wbv", wbv, 0);

    // Wrap-around: 20 loads through every stage
    for (int k = 0; k < 20; k++) begin
      disp(1, 0, (k + 10) % 64, 0);
      chk("wr_alloc", a1, (k + 1) % 8);
      rq_rdy = 1;
      addr(k % 8, 32'h1000 + 4 * k);
      chk("wr_reqv", rq_v, 1);
      chk("wr_addr", rq_addr, 32'h1000 + 4 * k);
      chk("wr_tag", rq_tag, k % 8);
      rs_v = 1; rs_tag = LQ_SEL'(k % 8); rs_data = 32'(k * 3 + 7);
      step();
      rs_v = 0; rq_rdy = 0;
      chk("wr_wbv", wbv, 1);
      chk("wr_wbp", wbp, (k + 10) % 64);
      chk("wr_wbd", wbd, k * 3 + 7);
      chk("wr_reqidle", rq_v, 0);
      cv = 1; step(); cv = 0;
      chk("wr_empty", empty, 1);
    end
    chk("wr_final_alloc", a1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
